lif_spike_monitor: RTL and testbench
====================================

// Module: lif_spike_monitor
// PURPOSE
//  Downstream consumer of the LIF neuron spike output. Counts spikes over a programmable window of clock cycles
//  and reports the per-window rate with a one-cycle valid strobe. Also tracks last and minimum inter-spike
//  interval (ISI). Sits between the neuron's spike pin and the chip-level outputs/uio readback.
// PARAMETERS
//  CNT_W  8   width of spike counter / rate output
//  WIN_W  16  width of window length, window counter and ISI counters
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      asynchronous reset, active-low
//  en          in   1      monitor enable; 0 = idle, partial window discarded
//  clear       in   1      synchronous clear of counters, ISI stats and window (not of rate/isi_last outputs)
//  spike       in   1      spike from neuron; each cycle high = one spike event
//  win_cycles  in   WIN_W  window length in cycles, sampled at window start; 0 treated as 1
//  rate        out  CNT_W  spike count of last completed window (saturating)
//  rate_valid  out  1      1-cycle pulse: rate updated this cycle
//  isi_last    out  WIN_W  cycles between the two most recent spikes (saturating)
//  isi_min     out  WIN_W  minimum ISI since reset/clear; all-ones = no interval seen yet
//  busy        out  1      1 while in RUN
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; rate=0, rate_valid=0, isi_last=0, isi_min=all-ones, busy=0; all counters 0.
//  FSM: IDLE -> RUN when en=1 (window start: latch win_cycles, win_cnt=0, spk_cnt=0).
//       RUN -> IDLE when en=0 (no rate_valid, partial count dropped). RUN stays RUN across windows.
//  In RUN each cycle: spk_cnt += spike (saturate at 2^CNT_W-1); win_cnt += 1.
//  Window end: cycle where win_cnt == latched_len-1. That cycle's spike IS counted; registered outputs show
//   rate=final count and rate_valid=1 on the next edge; same edge restarts window (relatch win_cycles,
//   win_cnt=0, spk_cnt=0). No dead cycle between windows; back-to-back windows of length N give a pulse every N.
//  Latency: spike in last window cycle -> rate_valid one cycle later. rate holds until next window end.
//  ISI: isi_cnt increments every cycle while en=1 (saturates at all-ones), independent of window.
//   On spike when a previous spike has been seen: isi_last <= isi_cnt+1 (sat), isi_min <= min(isi_min, that value),
//   isi_cnt <= 0. First spike after reset/clear only arms (isi_cnt <= 0, seen flag set); no ISI update.
//   Consecutive spike cycles give ISI=1.
//  clear=1 (sync, priority over everything except reset): spk_cnt=0, win_cnt=0, isi_cnt=0, seen=0,
//   isi_min=all-ones; if RUN, window restarts with current win_cycles; rate_valid=0 that cycle; spike in
//   clear cycle ignored.
//  en=0: ISI counters freeze (seen flag kept); rate/isi outputs hold.
//  win_cycles change mid-window: no effect until next window start.
//  Reset mid-window: immediate return to reset values, no rate_valid.
// STRUCTURE
//  Package lif_pkg: CNT_W/WIN_W defaults, state typedef (IDLE, RUN), ALL_ONES helpers.
//  Sub-module lif_sat_counter (param W; inc, clr, q, sat flag) instantiated for spk_cnt and isi_cnt.
//  Window counter, FSM and ISI compare live in this module; all outputs registered.
// TESTING
//  win_cycles=10, en rises at t0, spikes at window cycles 2,5,9 -> rate=3, rate_valid high exactly 1 cycle
//   after cycle 9; next pulse 10 cycles later with rate=0 if no spikes.
//  CNT_W=8, win_cycles=300, spike held 1 -> rate=255 (saturated), valid every 300 cycles.
//  Spikes 7 cycles apart then 3 apart (first spike arms) -> isi_last=7 then 3, isi_min=7 then 3; two
//   adjacent spike cycles -> isi_last=1.
//  en dropped at window cycle 4 of 10 -> no rate_valid, rate unchanged; en re-raised -> fresh 10-cycle window.
//  clear asserted together with spike mid-window -> spike not counted, isi_min=all-ones, window restarts.
//  rst_n pulsed low mid-window asynchronously (between edges) -> outputs reset immediately; win_cycles=0 -> valid every cycle.

Source files
------------

// File: rtl/lif_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lif_pkg
// Brief   : Shared widths, FSM state encoding and all-ones constants for the
//           LIF spike-rate / inter-spike-interval monitor.
// Revision: 1.0 - initial release
// ============================================================================
package lif_pkg;

    localparam int unsigned c_CNT_W_DEF = 8;
    localparam int unsigned c_WIN_W_DEF = 16;

    // One-bit state encoding with named codes
    typedef logic [0:0] state_t;
    localparam state_t c_ST_IDLE = 1'b0;
    localparam state_t c_ST_RUN  = 1'b1;

    // All-ones values at the default widths ("no interval seen" / saturation)
    localparam logic [c_CNT_W_DEF-1:0] c_CNT_ALL_ONES = {c_CNT_W_DEF{1'b1}};
    localparam logic [c_WIN_W_DEF-1:0] c_WIN_ALL_ONES = {c_WIN_W_DEF{1'b1}};

endpackage : lif_pkg
`default_nettype wire

// File: rtl/lif_sat_counter.sv
`default_nettype none
// ============================================================================
// Module  : lif_sat_counter
// Brief   : Up-counter that sticks at all-ones; clear has priority over inc.
// Revision: 1.0 - initial release
// ============================================================================
module lif_sat_counter
    import lif_pkg::*;
#(
    parameter int unsigned W = c_CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         sat
);

    logic [W-1:0] r_q;
    logic         w_sat;

    assign w_sat = &r_q;
    assign q     = r_q;
    assign sat   = w_sat;

    // Count register: clear wins, increment stops once all bits are set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && !w_sat) begin
            r_q <= r_q + 1'b1;
        end
    end

endmodule : lif_sat_counter
`default_nettype wire

// File: rtl/lif_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module  : lif_spike_monitor
// Brief   : Counts neuron spikes over a programmable window and reports the
//           per-window rate with a valid strobe; tracks last/min inter-spike
//           interval.
// Revision: 1.0 - initial release
// ============================================================================
module lif_spike_monitor
    import lif_pkg::*;
#(
    parameter int unsigned CNT_W = c_CNT_W_DEF,
    parameter int unsigned WIN_W = c_WIN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic             spike,
    input  logic [WIN_W-1:0] win_cycles,
    output logic [CNT_W-1:0] rate,
    output logic             rate_valid,
    output logic [WIN_W-1:0] isi_last,
    output logic [WIN_W-1:0] isi_min,
    output logic             busy
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIN_W-1:0] r_win_len;
    logic [WIN_W-1:0] r_win_cnt;
    logic [WIN_W-1:0] w_win_len_in;
    logic             w_run;
    logic             w_win_end;
    logic             w_win_start;

    logic [CNT_W-1:0] w_spk_q;
    logic             w_spk_sat;
    logic [CNT_W-1:0] w_rate_final;
    logic [CNT_W-1:0] r_rate;
    logic             r_rate_valid;

    logic [WIN_W-1:0] w_isi_q;
    logic             w_isi_sat;
    logic [WIN_W-1:0] w_isi_val;
    logic [WIN_W-1:0] r_isi_last;
    logic [WIN_W-1:0] r_isi_min;
    logic             r_seen;

    assign w_run        = (r_state == c_ST_RUN);
    // A zero-length window behaves as a one-cycle window
    assign w_win_len_in = (win_cycles == '0) ? WIN_W'(1) : win_cycles;
    // Last window cycle; clear or a dropped enable suppresses the strobe
    assign w_win_end    = w_run & en & ~clear & (r_win_cnt == r_win_len - WIN_W'(1));
    // Any event that (re)starts a window relatches the length
    assign w_win_start  = (~w_run & en) | w_win_end | clear;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enable alone moves between idle and run
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (en)  w_state_nxt = c_ST_RUN;
            c_ST_RUN:  if (!en) w_state_nxt = c_ST_IDLE;
            default:            w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Window length latch and position counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_len <= WIN_W'(1);
            r_win_cnt <= '0;
        end else if (w_win_start) begin
            r_win_len <= w_win_len_in;
            r_win_cnt <= '0;
        end else if (w_run && en) begin
            r_win_cnt <= r_win_cnt + 1'b1;
        end
    end

    // Spike counter: held at zero outside an active window
    lif_sat_counter #(.W(CNT_W)) u_spk_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_run & en & spike),
        .clr   (clear | ~w_run | ~en | w_win_end),
        .q     (w_spk_q),
        .sat   (w_spk_sat)
    );

    // The last-cycle spike is folded in here because the counter clears on that edge
    assign w_rate_final = w_spk_sat ? w_spk_q : (w_spk_q + CNT_W'(spike));

    // Rate output and its one-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rate       <= '0;
            r_rate_valid <= 1'b0;
        end else begin
            r_rate_valid <= w_win_end;
            if (w_win_end) begin
                r_rate <= w_rate_final;
            end
        end
    end

    // Inter-spike counter: runs whenever enabled, restarts on each spike
    lif_sat_counter #(.W(WIN_W)) u_isi_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (en),
        .clr   (clear | (en & spike)),
        .q     (w_isi_q),
        .sat   (w_isi_sat)
    );

    // Interval including the spike cycle itself, saturating
    assign w_isi_val = w_isi_sat ? w_isi_q : (w_isi_q + 1'b1);

    // ISI statistics: first spike after reset/clear only arms the tracker
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seen     <= 1'b0;
            r_isi_last <= '0;
            r_isi_min  <= '1;
        end else if (clear) begin
            r_seen    <= 1'b0;
            r_isi_min <= '1;
        end else if (en && spike) begin
            r_seen <= 1'b1;
            if (r_seen) begin
                r_isi_last <= w_isi_val;
                if (w_isi_val < r_isi_min) begin
                    r_isi_min <= w_isi_val;
                end
            end
        end
    end

    assign rate       = r_rate;
    assign rate_valid = r_rate_valid;
    assign isi_last   = r_isi_last;
    assign isi_min    = r_isi_min;
    assign busy       = w_run;

endmodule : lif_spike_monitor
`default_nettype wire

// File: tb/tb_lif_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_lif_spike_monitor
// Brief   : Directed self-checking bench for lif_spike_monitor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lif_spike_monitor;

    localparam int unsigned c_CNT_W = 8;
    localparam int unsigned c_WIN_W = 16;
    localparam logic [31:0] c_NO_ISI = 32'h0000_FFFF;

    logic               r_clk = 1'b0;
    logic               r_rst_n;
    logic               r_en;
    logic               r_clear;
    logic               r_spike;
    logic [c_WIN_W-1:0] r_win_cycles;
    logic [c_CNT_W-1:0] w_rate;
    logic               w_rate_valid;
    logic [c_WIN_W-1:0] w_isi_last;
    logic [c_WIN_W-1:0] w_isi_min;
    logic               w_busy;

    int n_cmp = 0;
    int n_err = 0;

    lif_spike_monitor #(.CNT_W(c_CNT_W), .WIN_W(c_WIN_W)) u_dut (
        .clk        (r_clk),
        .rst_n      (r_rst_n),
        .en         (r_en),
        .clear      (r_clear),
        .spike      (r_spike),
        .win_cycles (r_win_cycles),
        .rate       (w_rate),
        .rate_valid (w_rate_valid),
        .isi_last   (w_isi_last),
        .isi_min    (w_isi_min),
        .busy       (w_busy)
    );

    always #5 r_clk = ~r_clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    // Spike exactly gap cycles after the previous spike
    task automatic isi_gap(input int gap);
        r_spike = 1'b0;
        for (int i = 0; i < gap - 1; i++) step();
        r_spike = 1'b1;
        step();
        r_spike = 1'b0;
    endtask

    initial begin
        int pulses;
        r_rst_n      = 1'b0;
        r_en         = 1'b0;
        r_clear      = 1'b0;
        r_spike      = 1'b0;
        r_win_cycles = 16'd10;
        step();
        step();
        check_value("rst_rate",     32'(w_rate),       32'd0);
        check_value("rst_valid",    32'(w_rate_valid), 32'd0);
        check_value("rst_isi_last", 32'(w_isi_last),   32'd0);
        check_value("rst_isi_min",  32'(w_isi_min),    c_NO_ISI);
        check_value("rst_busy",     32'(w_busy),       32'd0);
        r_rst_n = 1'b1;
        step();

        // Window of 10 with spikes at window cycles 2, 5, 9
        r_en = 1'b1;
        step();
        check_value("win1_busy", 32'(w_busy), 32'd1);
        for (int k = 0; k < 10; k++) begin
            r_spike = (k == 2 || k == 5 || k == 9);
            check_value("win1_novalid", 32'(w_rate_valid), 32'd0);
            step();
        end
        r_spike = 1'b0;
        check_value("win1_valid",    32'(w_rate_valid), 32'd1);
        check_value("win1_rate",     32'(w_rate),       32'd3);
        check_value("win1_isi_last", 32'(w_isi_last),   32'd4);
        check_value("win1_isi_min",  32'(w_isi_min),    32'd3);

        // Drop enable at window cycle 4: partial window discarded, rate held
        for (int k = 0; k < 4; k++) step();
        check_value("drop_pre_valid", 32'(w_rate_valid), 32'd0);
        r_en = 1'b0;
        step();
        check_value("drop_busy", 32'(w_busy), 32'd0);
        for (int k = 0; k < 8; k++) begin
            check_value("drop_novalid", 32'(w_rate_valid), 32'd0);
            step();
        end
        check_value("drop_rate_held", 32'(w_rate), 32'd3);

        // Re-raise: fresh 10-cycle window, spikes at cycles 3 and 7
        r_en = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            r_spike = (k == 3 || k == 7);
            check_value("fresh_novalid", 32'(w_rate_valid), 32'd0);
            step();
        end
        r_spike = 1'b0;
        check_value("fresh_valid", 32'(w_rate_valid), 32'd1);
        check_value("fresh_rate",  32'(w_rate),       32'd2);
        step();
        check_value("fresh_pulse_width", 32'(w_rate_valid), 32'd0);

        // Back-to-back window with no spikes: rate 0 after 10 cycles
        for (int k = 0; k < 8; k++) begin
            step();
            check_value("empty_novalid", 32'(w_rate_valid), 32'd0);
        end
        step();
        check_value("empty_valid", 32'(w_rate_valid), 32'd1);
        check_value("empty_rate",  32'(w_rate),       32'd0);

        // ISI: clear statistics, arm, then gaps of 7, 3, 1
        r_clear = 1'b1;
        step();
        r_clear = 1'b0;
        check_value("isi_clr_min", 32'(w_isi_min), c_NO_ISI);
        r_spike = 1'b1;
        step();
        r_spike = 1'b0;
        check_value("isi_arm_min", 32'(w_isi_min), c_NO_ISI);
        isi_gap(7);
        check_value("isi7_last", 32'(w_isi_last), 32'd7);
        check_value("isi7_min",  32'(w_isi_min),  32'd7);
        isi_gap(3);
        check_value("isi3_last", 32'(w_isi_last), 32'd3);
        check_value("isi3_min",  32'(w_isi_min),  32'd3);
        isi_gap(1);
        check_value("isi1_last", 32'(w_isi_last), 32'd1);
        check_value("isi1_min",  32'(w_isi_min),  32'd1);

        // Clear together with a spike mid-window
        r_en = 1'b0;
        step();
        r_en = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            r_spike = (k == 1);
            step();
        end
        r_spike = 1'b1;
        r_clear = 1'b1;
        step();
        r_spike = 1'b0;
        r_clear = 1'b0;
        check_value("clr_valid",   32'(w_rate_valid), 32'd0);
        check_value("clr_isi_min", 32'(w_isi_min),    c_NO_ISI);
        for (int k = 0; k < 10; k++) begin
            r_spike = (k == 5);
            check_value("clr_novalid", 32'(w_rate_valid), 32'd0);
            step();
        end
        r_spike = 1'b0;
        check_value("clr_win_valid", 32'(w_rate_valid), 32'd1);
        check_value("clr_win_rate",  32'(w_rate),       32'd1);
        check_value("clr_arm_only",  32'(w_isi_min),    c_NO_ISI);

        // Saturation: window 300, spike held high
        r_en = 1'b0;
        step();
        r_win_cycles = 16'd300;
        r_en         = 1'b1;
        r_spike      = 1'b1;
        step();
        for (int w = 0; w < 2; w++) begin
            pulses = 0;
            for (int k = 0; k < 299; k++) begin
                step();
                if (w_rate_valid) pulses++;
            end
            check_value("sat_early_pulses", 32'(pulses), 32'd0);
            step();
            check_value("sat_valid", 32'(w_rate_valid), 32'd1);
            check_value("sat_rate",  32'(w_rate),       32'd255);
        end
        check_value("sat_isi_last", 32'(w_isi_last), 32'd1);

        // Asynchronous reset between edges, mid-window
        for (int k = 0; k < 5; k++) step();
        #2;
        r_rst_n = 1'b0;
        #1;
        check_value("arst_rate",     32'(w_rate),       32'd0);
        check_value("arst_valid",    32'(w_rate_valid), 32'd0);
        check_value("arst_isi_last", 32'(w_isi_last),   32'd0);
        check_value("arst_isi_min",  32'(w_isi_min),    c_NO_ISI);
        check_value("arst_busy",     32'(w_busy),       32'd0);
        r_spike = 1'b0;
        r_en    = 1'b0;
        step();
        r_rst_n = 1'b1;
        step();

        // Zero-length window: valid every cycle
        r_win_cycles = 16'd0;
        r_en         = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            check_value("w0_valid", 32'(w_rate_valid), 32'd1);
            check_value("w0_rate",  32'(w_rate),       32'd0);
        end
        r_spike = 1'b1;
        step();
        r_spike = 1'b0;
        check_value("w0_spk_valid", 32'(w_rate_valid), 32'd1);
        check_value("w0_spk_rate",  32'(w_rate),       32'd1);
        step();
        check_value("w0_after_rate", 32'(w_rate), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_lif_spike_monitor
`default_nettype wire
